ps2_kbd_rx_fifo: RTL and testbench
==================================

// Module: ps2_kbd_rx_fifo
// PURPOSE
// - PS/2 keyboard receiver: samples ps2_clk/ps2_data, deframes 11-bit frames, checks parity/stop.
// - Folds E0 (extended) and F0 (break) prefixes into flag bits; pushes each completed key event into a FIFO.
// - The CPU-side bus pops events through a show-ahead read port, so keypresses are not lost between polls.
// PARAMETERS
// - CLK_DIV      250  system clocks per sample tick; legal range 2..65535
// - FIFO_DEPTH   8    event FIFO entries; power of 2, 2..256
// - TIMEOUT_TK   64   sample ticks with no ps2_clk falling edge mid-frame before the frame is aborted
// PORTS
// - clk          in   1   system clock
// - rst          in   1   synchronous, active-high reset
// - ps2_clk      in   1   keyboard clock pin, asynchronous
// - ps2_data     in   1   keyboard data pin, asynchronous
// - rd_en        in   1   pop head entry; ignored when empty
// - rd_data      out  10  {ext, brk, scan[7:0]} of head entry; show-ahead
// - empty        out  1   FIFO holds no entries
// - full         out  1   FIFO holds FIFO_DEPTH entries
// - level        out  $clog2(FIFO_DEPTH)+1  number of entries held
// - overflow     out  1   sticky: an event was dropped because the FIFO was full
// - err_clr      in   1   clears overflow, parity_err and frame_err
// - parity_err   out  1   sticky: a frame failed the odd-parity check
// - frame_err    out  1   sticky: bad start bit, bad stop bit, or timeout
// BEHAVIOUR
// - Reset (clk edge with rst=1): all FSM/counter/FIFO state cleared.
//   - rd_data=0, empty=1, full=0, level=0.
//   - overflow, parity_err and frame_err = 0.
//   - ext and brk prefix flags = 0.
//   - Reset mid-frame discards the partial frame.
// - Synchroniser: ps2_clk and ps2_data each pass through 2 flops before any use.
// - Tick: divider counts 0..CLK_DIV-1; tick=1 for one clk cycle when it wraps.
//   - ps2_clk is sampled only on tick.
//   - A falling edge is a tick where the sample is 0 and the previous sample was 1.
// - Data is captured on each falling edge. FSM states:
//   - IDLE: falling edge with data=0 -> DATA, bit counter=0.
//     falling edge with data=1 -> set frame_err, stay in IDLE.
//   - DATA: shift data in LSB-first; after the 8th bit -> PARITY.
//   - PARITY: capture the parity bit -> STOP.
//   - STOP: data=1 and odd parity over the 9 bits -> byte accepted.
//     Bad parity sets parity_err; stop=0 sets frame_err.
//     Any error discards the byte and clears ext/brk. STOP always -> IDLE.
// - Timeout: in DATA, PARITY or STOP, a tick counter counts ticks since the last falling edge.
//   - Reaching TIMEOUT_TK sets frame_err, clears ext/brk and returns to IDLE.
// - Accepted byte decode, resolved in the same clk cycle as the STOP falling edge:
//   - E0: ext<=1, no push.
//   - F0: brk<=1, no push.
//   - Any other byte: push {ext,brk,byte}, then clear ext and brk.
//   - The push is visible (empty=0) on the following clk cycle.
// - FIFO:
//   - rd_data always shows the head entry; it is 0 when empty.
//   - rd_en pops one entry per clk cycle.
//   - Pop while empty: no effect, no error.
//   - Push while full without a same-cycle pop: event dropped, overflow<=1, FIFO contents unchanged.
//   - Push and pop in the same cycle: both performed (also when full), level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; level tracks occupancy exactly, 0..FIFO_DEPTH.
// - err_clr clears the sticky flags. If an error event occurs in the same cycle, set wins.
// TESTING
// - Frame 1C (parity 0, stop 1), CLK_DIV=4
//   -> one entry 0x01C, empty=0 one cycle after STOP, level=1.
// - Frames E0 F0 75 -> single entry 0x375 (ext=1, brk=1); level=1.
// - Frame 1C with parity bit flipped
//   -> parity_err=1, no push; next frame 32 -> entry 0x032 with no stale ext/brk.
// - Stop ps2_clk after 4 data bits for TIMEOUT_TK ticks
//   -> frame_err=1, FSM back in IDLE; next full frame 29 decodes correctly.
// - Push FIFO_DEPTH+1 events (8 for FIFO_DEPTH=8, then a 9th)
//   -> full=1, overflow=1, the 9th is lost; 8 pops return entries in order, then empty=1.
// - With full=1, assert rd_en in the STOP-accept cycle
//   -> level stays 8, overflow stays 0, new entry is last.
// - Assert rst mid-DATA
//   -> all outputs are reset values next cycle; a following frame decodes normally.

Source files
------------

// File: rtl/ps2_kbd_rx_fifo_if.sv
// Bus bundle for the PS/2 keyboard receiver: keyboard pins, CPU-side
// show-ahead FIFO read port and sticky error flags.
interface ps2_kbd_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          ps2_clk;
  logic          ps2_data;
  logic          rd_en;
  logic          err_clr;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic          parity_err;
  logic          frame_err;

  modport master (
    output ps2_clk, ps2_data, rd_en, err_clr,
    input  rd_data, empty, full, level, overflow, parity_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, rd_en, err_clr,
    output rd_data, empty, full, level, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// flag bits and queues key events in a show-ahead FIFO for the CPU.
module ps2_kbd_rx_fifo #(
  parameter int CLK_DIV    = 250,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_TK = 64
) (
  input  logic               clk,
  input  logic               rst,
  ps2_kbd_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TK + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic [DW-1:0] div_q;
  logic          clk_prev_q;
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q, brk_q;
  logic          perr_q, ferr_q, ovf_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic tick, fall, din, par_ok, stop_ok, push, timeout;
  logic pop, do_push, empty_w, full_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
    end
  end

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall    = tick & clk_prev_q & ~clk_sync_q[1];
  assign din     = dat_sync_q[1];
  assign par_ok  = ^{shift_q, par_q};
  assign stop_ok = (state_q == STOP) && fall && din && par_ok;
  assign push    = stop_ok && (shift_q != 8'hE0) && (shift_q != 8'hF0);
  assign timeout = (state_q != IDLE) && tick && !fall &&
                   (to_cnt_q == TW'(TIMEOUT_TK - 1));

  // Frame FSM; error set assignments come after err_clr so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (fall || state_q == IDLE) to_cnt_q <= '0;
      else if (tick)               to_cnt_q <= to_cnt_q + 1'b1;

      if (timeout) begin
        state_q <= IDLE;
        ferr_q  <= 1'b1;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!din) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              ferr_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q   <= {din, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= din;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (stop_ok) begin
              if (shift_q == 8'hE0)      ext_q <= 1'b1;
              else if (shift_q == 8'hF0) brk_q <= 1'b1;
              else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end
            end else begin
              if (!din)    ferr_q <= 1'b1;
              if (!par_ok) perr_q <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LW'(FIFO_DEPTH));
  assign pop     = bus.rd_en && !empty_w;
  // When full, a same-cycle pop frees the head slot that wr_ptr points at
  assign do_push = push && (!full_w || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.err_clr)      ovf_q <= 1'b0;
      if (push && !do_push) ovf_q <= 1'b1;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.rd_data    = empty_w ? 10'd0 : mem_q[rd_ptr_q];
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.level      = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench for ps2_kbd_rx_fifo: bit-banged PS/2 frames with
// hand-computed key events, prefix folding, error flags and FIFO limits.
module tb_ps2_kbd_rx_fifo;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ps2_kbd_rx_fifo_if #(.FIFO_DEPTH(8)) bus ();

  ps2_kbd_rx_fifo #(
    .CLK_DIV(4), .FIFO_DEPTH(8), .TIMEOUT_TK(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits of an 11-bit frame; data changes while ps2_clk is high
  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, bus.rd_data}, {22'd0, exp});
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    bit seen;
    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd_en    = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_rd_data", {22'd0, bus.rd_data}, 32'h0);
    chk("rst_empty",   {31'd0, bus.empty}, 32'd1);
    chk("rst_full",    {31'd0, bus.full}, 32'd0);
    chk("rst_level",   {28'd0, bus.level}, 32'd0);
    chk("rst_ovf",     {31'd0, bus.overflow}, 32'd0);
    chk("rst_perr",    {31'd0, bus.parity_err}, 32'd0);
    chk("rst_ferr",    {31'd0, bus.frame_err}, 32'd0);

    // Plain make code
    send_frame(8'h1C, 0, 0, 11);
    chk("k1c_empty", {31'd0, bus.empty}, 32'd0);
    chk("k1c_level", {28'd0, bus.level}, 32'd1);
    pop_chk("k1c_data", 10'h01C);
    chk("k1c_empty_after", {31'd0, bus.empty}, 32'd1);

    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("pop_empty_level", {28'd0, bus.level}, 32'd0);
    chk("pop_empty_ovf",   {31'd0, bus.overflow}, 32'd0);

    // Extended break: E0 F0 75
    send_frame(8'hE0, 0, 0, 11);
    chk("e0_nopush", {31'd0, bus.empty}, 32'd1);
    send_frame(8'hF0, 0, 0, 11);
    chk("f0_nopush", {31'd0, bus.empty}, 32'd1);
    send_frame(8'h75, 0, 0, 11);
    chk("e0f075_level", {28'd0, bus.level}, 32'd1);
    pop_chk("e0f075_data", 10'h375);

    // Bad parity after an E0 prefix, then clean byte without stale flags
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h1C, 1, 0, 11);
    chk("par_perr",  {31'd0, bus.parity_err}, 32'd1);
    chk("par_ferr",  {31'd0, bus.frame_err}, 32'd0);
    chk("par_empty", {31'd0, bus.empty}, 32'd1);
    send_frame(8'h32, 0, 0, 11);
    pop_chk("par_next", 10'h032);
    clear_errs();
    chk("clr_perr", {31'd0, bus.parity_err}, 32'd0);

    // Bad stop bit
    send_frame(8'h16, 0, 1, 11);
    chk("stop_ferr",  {31'd0, bus.frame_err}, 32'd1);
    chk("stop_empty", {31'd0, bus.empty}, 32'd1);
    clear_errs();
    chk("clr_ferr", {31'd0, bus.frame_err}, 32'd0);

    // Timeout: start + 4 data bits, then ps2_clk idle for >64 ticks
    send_frame(8'h29, 0, 0, 5);
    repeat (300) @(negedge clk);
    chk("to_ferr",  {31'd0, bus.frame_err}, 32'd1);
    chk("to_empty", {31'd0, bus.empty}, 32'd1);
    send_frame(8'h29, 0, 0, 11);
    pop_chk("to_next", 10'h029);
    clear_errs();

    // Overflow: nine events into an 8-entry FIFO
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0, 11);
    chk("ovf_full",  {31'd0, bus.full}, 32'd1);
    chk("ovf_flag",  {31'd0, bus.overflow}, 32'd1);
    chk("ovf_level", {28'd0, bus.level}, 32'd8);
    for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 10'h010 + 10'(i));
    chk("ovf_drained", {31'd0, bus.empty}, 32'd1);
    clear_errs();
    chk("clr_ovf", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO with a pop coinciding with the push cycle
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 0, 0, 11);
    chk("pp_full", {31'd0, bus.full}, 32'd1);
    send_frame(8'h28, 0, 0, 10);
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dut.push) seen = 1'b1;
    end
    chk("pp_push_seen", {31'd0, seen}, 32'd1);
    chk("pp_head", {22'd0, bus.rd_data}, 32'h020);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("pp_level", {28'd0, bus.level}, 32'd8);
    chk("pp_ovf",   {31'd0, bus.overflow}, 32'd0);
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 8; i++) pop_chk("pp_pop", 10'h021 + 10'(i));
    chk("pp_drained", {31'd0, bus.empty}, 32'd1);

    // Reset in the middle of a frame with state to discard
    send_frame(8'h55, 0, 0, 11);
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h1C, 1, 0, 11);
    send_frame(8'h44, 0, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rd_data", {22'd0, bus.rd_data}, 32'h0);
    chk("mrst_empty",   {31'd0, bus.empty}, 32'd1);
    chk("mrst_level",   {28'd0, bus.level}, 32'd0);
    chk("mrst_perr",    {31'd0, bus.parity_err}, 32'd0);
    chk("mrst_ferr",    {31'd0, bus.frame_err}, 32'd0);
    repeat (H) @(negedge clk);
    send_frame(8'h5A, 0, 0, 11);
    chk("mrst_level1", {28'd0, bus.level}, 32'd1);
    pop_chk("mrst_next", 10'h05A);
    chk("mrst_ferr_after", {31'd0, bus.frame_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
